// File: rtl/fp_result_buffer.sv
// fp_result_buffer: FWFT queue of multiplier results with sticky drop flag; FP_RESBUF_CLASS_EN adds per-entry class tags
module fp_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [31:0]      res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_class,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow,
  input  logic             ovf_clr
);
  localparam int AW = $clog2(DEPTH);
`ifdef FP_RESBUF_CLASS_EN
  localparam int SW = 36;
  logic [7:0]  e;
  logic [22:0] m;
  assign e = res[30:23];
  assign m = res[22:0];
`else
  localparam int SW = 32;
`endif
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
`ifdef FP_RESBUF_CLASS_EN
  assign entry = {e == 8'hff && m != '0, e == 8'hff && m == '0, e == '0 && m == '0, e == '0 && m != '0, res};
`else
  assign entry = res;
`endif
  assign out_valid = count != '0;
  assign full      = count == CNT_W'(DEPTH);
  assign pop       = out_valid && out_ready;
  assign push      = done && (!full || pop);
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[31:0] : '0;
`ifdef FP_RESBUF_CLASS_EN
  assign out_class = out_valid ? head[35:32] : '0;
`else
  assign out_class = 4'b0000;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= entry;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      overflow <= (done && full && !pop) || (overflow && !ovf_clr);
    end
endmodule

// File: tb/tb_fp_result_buffer.sv
// tb_fp_result_buffer: randomized + directed scoreboard bench for fp_result_buffer
module tb_fp_result_buffer;
  localparam int DEPTH = 8;
  logic        clk = 0, rst = 0, done = 0, out_ready = 0, ovf_clr = 0;
  logic [31:0] res = 0;
  logic        out_valid, full, overflow;
  logic [31:0] out_data;
  logic [3:0]  out_class;
  logic [3:0]  count;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic        ovf_m = 0;

  fp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .done(done), .res(res), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .count(count), .full(full), .overflow(overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  function automatic logic [3:0] cls_of(logic [31:0] v);
`ifdef FP_RESBUF_CLASS_EN
    if (v[30:23] == 8'd255) return (v[22:0] != 0) ? 4'b1000 : 4'b0100;
    if (v[30:23] == 8'd0) return (v[22:0] == 0) ? 4'b0010 : 4'b0001;
`endif
    return 4'b0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue semantics straight from the push/pop/drop rules
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      ovf_m <= 0;
    end else begin
      automatic bit pop_m = (q.size() > 0) && out_ready;
      automatic bit drop = done && q.size() == DEPTH && !pop_m;
      if (pop_m) void'(q.pop_front());
      if (done && !drop) q.push_back(res);
      ovf_m <= drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_m);
    end
  end

  // monitor: compare DUT head and status against the model every cycle
  always @(negedge clk) if (rst) begin
    chk("valid", out_valid, q.size() > 0);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, ovf_m);
    if (q.size() > 0) begin
      chk("data", out_data, q[0]);
      chk("class", out_class, cls_of(q[0]));
    end else begin
      chk("data_empty", out_data, 0);
      chk("class_empty", out_class, 0);
    end
  end

  task automatic step(logic d, logic [31:0] r, logic rdy, logic clr);
    done = d; res = r; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drain(output logic [31:0] last);
    int n = 0;
    last = 0;
    while (out_valid && n < 4 * DEPTH) begin
      last = out_data;
      step(0, 0, 1, 0);
      n++;
    end
    chk("drain_bound", {31'b0, out_valid}, 0);
  endtask

  logic [31:0] last;
  logic [31:0] t5 [5] = '{32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000001, 32'h40A00000};
  logic [3:0]  c5 [5];

  initial begin
`ifdef FP_RESBUF_CLASS_EN
    c5 = '{4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
`else
    c5 = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    @(negedge clk); #1;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk); #1;
    rst = 1;
    // 1: two back-to-back results with consumer ready
    step(1, 32'h40A00000, 1, 0);
    chk("t1_valid", {31'b0, out_valid}, 1);
    chk("t1_first", out_data, 32'h40A00000);
    step(1, 32'h3FA00000, 1, 0);
    chk("t1_second", out_data, 32'h3FA00000);
    step(0, 0, 1, 0);
    chk("t1_count", {28'b0, count}, 0);
    chk("t1_ovf", {31'b0, overflow}, 0);
    // 2: overfill with consumer stalled
    for (int i = 1; i <= DEPTH + 1; i++) step(1, i, 0, 0);
    chk("t2_count", {28'b0, count}, DEPTH);
    chk("t2_full", {31'b0, full}, 1);
    chk("t2_ovf", {31'b0, overflow}, 1);
    drain(last);
    chk("t2_last", last, DEPTH);
    // 6a: clear with no drop
    step(0, 0, 0, 1);
    chk("t6_clear", {31'b0, overflow}, 0);
    // 3: simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + i, 0, 0);
    step(1, 32'hAA, 1, 0);
    chk("t3_count", {28'b0, count}, DEPTH);
    chk("t3_ovf", {31'b0, overflow}, 0);
    drain(last);
    chk("t3_last", last, 32'hAA);
    // 6b: clear coinciding with a drop
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0);
    step(1, 32'h55, 0, 1);
    chk("t6_set_wins", {31'b0, overflow}, 1);
    step(0, 0, 0, 1);
    chk("t6_clear2", {31'b0, overflow}, 0);
    drain(last);
    // 4: async reset mid-cycle
    for (int i = 0; i < 3; i++) step(1, 32'h200 + i, 0, 0);
    done = 0;
    #1 rst = 0;
    #1;
    chk("t4_valid", {31'b0, out_valid}, 0);
    chk("t4_count", {28'b0, count}, 0);
    chk("t4_full", {31'b0, full}, 0);
    @(negedge clk); #1;
    rst = 1;
    step(1, 32'h12345678, 0, 0);
    chk("t4_first", out_data, 32'h12345678);
    drain(last);
    // 5: class tags
    for (int i = 0; i < 5; i++) step(1, t5[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_class", {28'b0, out_class}, {28'b0, c5[i]});
      step(0, 0, 1, 0);
    end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      automatic logic [31:0] r = $urandom;
      case ($urandom_range(0, 5))
        0: r[30:23] = 8'hFF;
        1: r[30:23] = 8'h00;
        2: r[22:0] = 0;
        default: ;
      endcase
      step($urandom_range(0, 99) < 55, r, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10);
    end
    drain(last);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
